// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_write_arbiter : round-robin sharing of the two register-file write
// ports among NREQ writeback requesters, with registered output stage.
// Revision : 1.0
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 4,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rd_wen,
  output logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic                 rs_wen,
  output logic [AW-1:0]        rs_addr,
  output logic [DW-1:0]        rs_data,
  output logic [(2**AW)-1:0]   pending_mask,
  output logic [15:0]          conflict_count
);

  localparam int PW = $clog2(NREQ);

  logic [AW-1:0] addr_arr [NREQ];
  logic [DW-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*AW +: AW];
    assign data_arr[i] = req_data[i*DW +: DW];
  end

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW:0]   sum;
  logic [PW-1:0] a_idx;
  logic [PW-1:0] b_idx;
  logic [AW-1:0] a_addr;
  logic          a_found;
  logic          b_found;
  logic          collide;
  logic          grant_en;
  logic          a_grant;
  logic          b_grant;
  logic          hit;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // A collision only counts while port B is still open; once both ports are
  // taken the requester would have been denied regardless of its address.
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    collide = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    a_addr  = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (req_valid[idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = idx;
          a_addr  = addr_arr[idx];
        end else if (addr_arr[idx] == a_addr) begin
          if (!b_found) collide = 1'b1;
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = idx;
        end
      end
    end
  end

  assign grant_en = rst_n & ~stall;
  assign a_grant  = a_found & grant_en;
  assign b_grant  = b_found & grant_en;
  assign hit      = collide & grant_en;

  always_comb begin
    req_ready = '0;
    if (a_grant) req_ready[a_idx] = 1'b1;
    if (b_grant) req_ready[b_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr            <= '0;
      rd_wen         <= 1'b0;
      rd_addr        <= '0;
      rd_data        <= '0;
      rs_wen         <= 1'b0;
      rs_addr        <= '0;
      rs_data        <= '0;
      conflict_count <= '0;
    end else begin
      rd_wen <= a_grant;
      rs_wen <= b_grant;
      if (a_grant) begin
        rd_addr <= addr_arr[a_idx];
        rd_data <= data_arr[a_idx];
      end
      if (b_grant) begin
        rs_addr <= addr_arr[b_idx];
        rs_data <= data_arr[b_idx];
      end
      if (b_grant) begin
        ptr <= wrap_inc(b_idx);
      end else if (a_grant) begin
        ptr <= wrap_inc(a_idx);
      end
      if (hit && (conflict_count != 16'hFFFF)) begin
        conflict_count <= conflict_count + 16'd1;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    if (rd_wen) pending_mask[rd_addr] = 1'b1;
    if (rs_wen) pending_mask[rs_addr] = 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// Scoreboard bench for regfile_write_arbiter: stimulus pushes expected
// register-file writes, a forked monitor pops them when a Wen appears.
module tb_regfile_write_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                stall;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                rd_wen;
  logic [AW-1:0]       rd_addr;
  logic [DW-1:0]       rd_data;
  logic                rs_wen;
  logic [AW-1:0]       rs_addr;
  logic [DW-1:0]       rs_data;
  logic [(2**AW)-1:0]  pending_mask;
  logic [15:0]         conflict_count;

  regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .rd_wen         (rd_wen),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rs_wen         (rs_wen),
    .rs_addr        (rs_addr),
    .rs_data        (rs_data),
    .pending_mask   (pending_mask),
    .conflict_count (conflict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  aa;
    logic [15:0] da;
    logic        pb;
    logic [3:0]  ab;
    logic [15:0] db;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic set3(input logic [2:0] v, input logic [3:0] a0, input logic [3:0] a1,
                      input logic [3:0] a2, input logic [15:0] d0, input logic [15:0] d1,
                      input logic [15:0] d2);
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic step(input string nm, input logic [2:0] er,
                      input logic pa, input logic [3:0] aa, input logic [15:0] da,
                      input logic pb, input logic [3:0] ab, input logic [15:0] db);
    exp_t e;
    #1;
    check({nm, "_ready"}, 64'(req_ready), 64'(er));
    if (pa) begin
      e.aa = aa; e.da = da; e.pb = pb; e.ab = ab; e.db = db;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  fa [3];
    logic [15:0] fd [3];
    int          cnt [3];
    int          last [3];
    int          maxgap;
    int          mptr;
    logic [2:0]  er;
    exp_t        fe;

    fork
      forever begin
        exp_t        e;
        logic [15:0] m;
        @(negedge clk);
        if (rst_n && (rd_wen || rs_wen)) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got rd_wen=%0b rs_wen=%0b expected no write", rd_wen, rs_wen);
          end else begin
            e = sb.pop_front();
            check("mon_rd_wen",  64'(rd_wen),  64'd1);
            check("mon_rd_addr", 64'(rd_addr), 64'(e.aa));
            check("mon_rd_data", 64'(rd_data), 64'(e.da));
            check("mon_rs_wen",  64'(rs_wen),  64'(e.pb));
            if (e.pb) begin
              check("mon_rs_addr", 64'(rs_addr), 64'(e.ab));
              check("mon_rs_data", 64'(rs_data), 64'(e.db));
            end
            m = '0;
            m[e.aa] = 1'b1;
            if (e.pb) m[e.ab] = 1'b1;
            check("mon_pending", 64'(pending_mask), 64'(m));
          end
        end
      end
    join_none

    fa[0] = 4'd1;  fa[1] = 4'd2;  fa[2] = 4'd5;
    fd[0] = 16'h1001; fd[1] = 16'h1002; fd[2] = 16'h1005;

    // Reset with every requester valid.
    rst_n = 1'b0;
    stall = 1'b0;
    set3(3'b111, 4'd3, 4'd4, 4'd5, 16'h1111, 16'h2222, 16'h3333);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",    64'(req_ready),      64'd0);
    check("rst_rd_wen",   64'(rd_wen),         64'd0);
    check("rst_rs_wen",   64'(rs_wen),         64'd0);
    check("rst_pending",  64'(pending_mask),   64'd0);
    check("rst_conflict", 64'(conflict_count), 64'd0);

    // Single requester after reset release (ptr 0 -> 1).
    rst_n = 1'b1;
    set3(3'b001, 4'd3, 4'd0, 4'd0, 16'h1234, 16'h0000, 16'h0000);
    step("t1_single", 3'b001, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0);
    // Requester 2 alone brings ptr back to 0.
    set3(3'b100, 4'd0, 4'd0, 4'd4, 16'h0, 16'h0, 16'h2222);
    step("t1_r2", 3'b100, 1'b1, 4'd4, 16'h2222, 1'b0, 4'd0, 16'h0);

    // Dual grant from ptr 0, then from ptr 2 (wraps to requester 0).
    set3(3'b111, fa[0], fa[1], fa[2], fd[0], fd[1], fd[2]);
    step("t2_dual0", 3'b011, 1'b1, 4'd1, 16'h1001, 1'b1, 4'd2, 16'h1002);
    step("t2_dual1", 3'b101, 1'b1, 4'd5, 16'h1005, 1'b1, 4'd1, 16'h1001);
    check("t2_conflict", 64'(conflict_count), 64'd0);

    // Collision: ptr 1 -> requester 2 alone returns ptr to 0.
    set3(3'b100, 4'd0, 4'd0, 4'd6, 16'h0, 16'h0, 16'h3333);
    step("t3_prep", 3'b100, 1'b1, 4'd6, 16'h3333, 1'b0, 4'd0, 16'h0);
    set3(3'b111, 4'd7, 4'd7, 4'd9, 16'h7000, 16'h7001, 16'h9002);
    step("t3_coll", 3'b101, 1'b1, 4'd7, 16'h7000, 1'b1, 4'd9, 16'h9002);
    check("t3_conflict_inc", 64'(conflict_count), 64'd1);
    set3(3'b010, 4'd7, 4'd7, 4'd9, 16'h7000, 16'h7001, 16'h9002);
    step("t3_retry", 3'b010, 1'b1, 4'd7, 16'h7001, 1'b0, 4'd0, 16'h0);
    check("t3_conflict_hold", 64'(conflict_count), 64'd1);

    // Stall: ptr 2 grants req2/req0, then 4 stalled cycles with colliding addresses.
    set3(3'b111, fa[0], fa[1], fa[2], fd[0], fd[1], fd[2]);
    step("t4_pre", 3'b101, 1'b1, 4'd5, 16'h1005, 1'b1, 4'd1, 16'h1001);
    stall = 1'b1;
    set3(3'b111, 4'd7, 4'd7, 4'd9, 16'h7000, 16'h7001, 16'h9002);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        check("t4_stall_rd_wen", 64'(rd_wen), 64'd0);
        check("t4_stall_rs_wen", 64'(rs_wen), 64'd0);
      end
      step("t4_stall", 3'b000, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    end
    check("t4_conflict", 64'(conflict_count), 64'd1);
    stall = 1'b0;

    // Fairness: ptr starts at 1, every cycle grants ptr and ptr+1.
    set3(3'b111, fa[0], fa[1], fa[2], fd[0], fd[1], fd[2]);
    mptr = 1;
    maxgap = 0;
    for (int i = 0; i < 3; i++) begin
      cnt[i]  = 0;
      last[i] = -1;
    end
    for (int c = 0; c < 30; c++) begin
      int a;
      int b;
      a = mptr;
      b = (mptr + 1) % 3;
      er = 3'b000;
      er[a] = 1'b1;
      er[b] = 1'b1;
      #1;
      check("fair_ready", 64'(req_ready), 64'(er));
      for (int i = 0; i < 3; i++) begin
        if (req_ready[i]) begin
          cnt[i]++;
          if (last[i] >= 0 && (c - last[i]) > maxgap) maxgap = c - last[i];
          last[i] = c;
        end
      end
      fe.aa = fa[a]; fe.da = fd[a]; fe.pb = 1'b1; fe.ab = fa[b]; fe.db = fd[b];
      sb.push_back(fe);
      mptr = (mptr + 2) % 3;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) check("fair_count", 64'(cnt[i]), 64'd20);
    check("fair_maxgap", 64'(maxgap), 64'd2);

    // Drain, then reset while a write is registered (ptr is 1 here).
    set3(3'b000, fa[0], fa[1], fa[2], fd[0], fd[1], fd[2]);
    step("t6_drain", 3'b000, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    set3(3'b111, fa[0], fa[1], fa[2], fd[0], fd[1], fd[2]);
    #1;
    check("t6_pre_ready", 64'(req_ready), 64'b110);
    @(posedge clk);
    #1;
    check("t6_wen_before", 64'(rd_wen), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rd_wen_async", 64'(rd_wen),         64'd0);
    check("t6_rs_wen_async", 64'(rs_wen),         64'd0);
    check("t6_pending",      64'(pending_mask),   64'd0);
    check("t6_ready",        64'(req_ready),      64'd0);
    check("t6_conflict",     64'(conflict_count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("t6_restart", 3'b011, 1'b1, 4'd1, 16'h1001, 1'b1, 4'd2, 16'h1002);
    set3(3'b000, fa[0], fa[1], fa[2], fd[0], fd[1], fd[2]);
    step("t6_idle0", 3'b000, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    step("t6_idle1", 3'b000, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the two register-file write ports (Rd write port = port A, Rs write port = port B) between NREQ writeback requesters, e.g. ALU, load/store and multiplier.
- Round-robin arbitration grants up to two writes per cycle.
- Two grants in the same cycle never target the same register.
- Grants are registered into a one-cycle output stage that drives the register file directly, and a pending mask is exported for hazard checks.

Parameters:
- NREQ, 3, number of writeback requesters (2..8)
- AW, 4, register address width
- DW, 16, data width

Ports:
- Clock  in  1  sole clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- Stall  in  1  when high, no grants this cycle
- Req_Valid  in  NREQ  requester i has a write pending
- Req_Addr  in  NREQ*AW  packed; requester i at bits [i*AW +: AW]
- Req_Data  in  NREQ*DW  packed; requester i at bits [i*DW +: DW]
- Req_Ready  out  NREQ  combinational grant; a transfer occurs when Valid and Ready are both high
- Rd_Wen  out  1  port A write enable (registered)
- Rd_Addr  out  AW  port A address (registered)
- Rd_Data  out  DW  port A data (registered)
- Rs_Wen  out  1  port B write enable (registered)
- Rs_Addr  out  AW  port B address (registered)
- Rs_Data  out  DW  port B data (registered)
- Pending_Mask  out  2**AW  one-hot OR of the currently driven write addresses
- Conflict_Count  out  16  saturating count of collision-denied cycles

Behaviour:
- Reset (asynchronous, Reset_n low):
  - Ptr=0; Rd_Wen=Rs_Wen=0; all addresses, data and Conflict_Count = 0.
  - Req_Ready is forced to 0 while Reset_n is low.
  - Assertion mid-operation drops any registered writes immediately; Wen falls without waiting for a clock edge.
- Arbitration (combinational, each cycle):
  - If Stall=1, Req_Ready=0 for every requester.
  - Otherwise scan requesters in order Ptr, Ptr+1, ... wrapping modulo NREQ.
  - The first valid requester is granted port A.
  - The next valid requester whose address differs from port A's address is granted port B.
  - A valid requester whose address equals port A's address is skipped and denied; the scan continues past it.
  - At most two Ready bits are high in any cycle.
  - Ready of a requester never depends on its own Ready.
- Output stage (rising edge):
  - Rd_Wen <= port A granted; Rd_Addr/Rd_Data <= the granted requester's address/data.
  - Rs_Wen <= port B granted; Rs_Addr/Rs_Data <= the granted requester's address/data.
  - Latency from transfer to register-file write enable is exactly 1 cycle.
  - Addr/Data hold their previous value when the corresponding Wen is 0.
- Pointer:
  - If any grant occurred, Ptr <= (index of the last granted requester + 1) mod NREQ.
  - With no grants, Ptr is unchanged.
  - This guarantees every continuously valid requester is granted within NREQ cycles, unless it is blocked by repeated same-address collisions.
- Pending_Mask:
  - bit Rd_Addr set if Rd_Wen; bit Rs_Addr set if Rs_Wen; all other bits 0.
  - Decoded from the output flops.
- Conflict_Count:
  - +1 on each rising edge where Stall=0 and at least one valid requester was denied solely because of an address collision.
  - Saturates at 16'hFFFF.
  - Counts at most once per cycle.
- Requester obligations:
  - Once Valid is asserted, Addr/Data must stay stable until the transfer.
  - The arbiter does not check this.
- Stall:
  - Does not affect the output stage.
  - Writes already registered still complete in the next cycle.

Test Plan:
1. Reset then idle: Reset_n low with all Valid=1 -> Req_Ready=000, Rd_Wen=Rs_Wen=0, Pending_Mask=0. Release reset with requester 0 alone valid (addr 3, data 16'h1234) -> Ready=001; next cycle Rd_Wen=1, Rd_Addr=3, Rd_Data=16'h1234, Pending_Mask=16'h0008.
2. Dual grant: Ptr=0, all three valid with addrs 1, 2, 5 -> Ready=011; next cycle Rd=(1, data0) and Rs=(2, data1); Ptr=2. Next cycle with all still valid -> requester 2 gets port A and requester 0 gets port B.
3. Collision: requesters 0 and 1 both target addr 7, requester 2 targets addr 9, Ptr=0 -> Ready=101; Conflict_Count increments by 1; port B carries addr 9; requester 1 is granted the next cycle.
4. Stall: all valid, Stall=1 for 4 cycles -> Ready=000 throughout and Conflict_Count unchanged. The previously registered write still appears on the first stalled cycle, then Wen=0.
5. Fairness: all requesters continuously valid with distinct addresses for 30 cycles -> each requester completes 20 grants (±1), and no requester waits more than 2 cycles between grants.
6. Reset mid-write: Reset_n pulled low between edges while Rd_Wen=1 -> Rd_Wen drops immediately and Ptr=0. After release, the scan restarts from requester 0.
